ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage. Consumes the ID/EX pipeline register outputs and produces registered results for the EX/MEM register.
- Single-cycle ALU ops finish in one cycle.
- Iterative 32-cycle multiply/divide unit raises stall_req_o toward the hazard unit, which freezes PC, IF/ID and ID/EX.
- Also computes the branch target and the zero flag for the MEM-stage branch decision.

Parameters:
- XLEN, 32, operand/result width.
- REG_AW, 5, register address width.
- ALUOP_W, 4, ALU opcode width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush_i  in  1  kill in-flight op; force bubble
- issue_i  in  1  ID/EX holds a valid instruction this cycle
- pc_i  in  XLEN  instruction PC
- reg1_data_i  in  XLEN  operand A
- reg2_data_i  in  XLEN  rs2 value
- imm_data_i  in  XLEN  sign-extended immediate
- ctrl_ex_AluSrc_i  in  1  1: operand B = imm_data_i; 0: operand B = reg2_data_i
- alu_op_i  in  ALUOP_W  operation select
- write_addr_i  in  REG_AW  destination register
- ctrl_wb_RegWrite_i, ctrl_wb_Mem2Reg_i, ctrl_mem_branch_i, ctrl_mem_read_i, ctrl_mem_write_i  in  1 each  passed downstream
- valid_o  out  1  result valid in EX/MEM
- result_o  out  XLEN  ALU/mul/div result
- store_data_o  out  XLEN  registered reg2_data_i
- branch_target_o  out  XLEN  pc_i + imm_data_i
- zero_o  out  1  result_o == 0
- write_addr_o  out  REG_AW
- ctrl_*_o  out  1 each  registered copies of the five ctrl_* inputs
- stall_req_o  out  1  freeze upstream stages (combinational)
- illegal_o  out  1  unsupported alu_op_i retired (registered)

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous, active-high.
- Reset and flush:
  - All outputs are 0 and state = IDLE after the edge where rst=1.
  - flush_i takes the same action, except result_o, store_data_o, branch_target_o and write_addr_o hold their values.
  - Priority: rst > flush_i > issue_i.
- Bubble:
  - IDLE with issue_i=0 gives valid_o=0, all ctrl_*_o=0 and illegal_o=0.
  - Data outputs hold.
- alu_op_i encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA: shift amount is B[4:0]
  - 8 SLT (signed), 9 SLTU: result is 0 or 1
  - 10 MUL (low XLEN bits), 11 MULHU (high XLEN bits, unsigned)
  - 12 DIVU, 13 REMU
  - 14 and 15 are illegal: result 0, illegal_o=1 with valid_o.
- Arithmetic wraps modulo 2^XLEN. branch_target_o wraps.
- Single-cycle ops (0-9, 14, 15):
  - Issue in IDLE; all outputs are registered at the next edge with valid_o=1.
  - Latency 1. stall_req_o stays 0.
- FSM states: IDLE, MUL_BUSY, DIV_BUSY.
- IDLE with issue_i and op 10-13:
  - stall_req_o=1 combinationally.
  - At the edge: latch A, B, op, write_addr and ctrl; count=0; go to MUL_BUSY (ops 10-11) or DIV_BUSY (ops 12-13).
  - valid_o=0 at that edge.
- MUL_BUSY:
  - Shift-add, one bit per cycle, 64-bit accumulator.
  - count increments 0..31.
- DIV_BUSY:
  - Restoring division, one quotient bit per cycle.
  - count increments 0..31.
- Busy-state stall:
  - stall_req_o = 1 while busy and count != 31.
  - In the count==31 cycle stall_req_o = 0, so ID/EX advances at the same edge the result retires.
- Retire edge (end of count==31 cycle):
  - Result registered, valid_o=1, latched ctrl/write_addr driven, state = IDLE.
  - Total: result visible 33 cycles after the issue cycle.
- issue_i is ignored while busy.
- Divide by zero:
  - DIVU gives all ones.
  - REMU gives the dividend.
  - Runs the full 32 cycles anyway, so latency is deterministic.
- flush_i while busy:
  - Aborts to IDLE and drops stall_req_o the same cycle.
  - No valid_o is produced for the aborted op.
- valid_o is a one-cycle pulse per retired instruction. Back-to-back single-cycle issues give valid_o=1 every cycle.

Optional Feature:
- Macro: EX_MULDIV_EN.
- Defined: MUL_BUSY/DIV_BUSY and the iterative unit are present, as described above.
- Undefined:
  - Ops 10-13 are treated as illegal: single-cycle, result 0, illegal_o=1.
  - FSM reduces to IDLE only.
  - stall_req_o is tied to 0.

Test Plan:
- ADD, A=0xFFFFFFFF, imm=1, AluSrc=1, issue one cycle -> next cycle valid_o=1, result_o=0, zero_o=1; with pc_i=0x100 and imm=1, branch_target_o=0x101.
- SRA A=0x80000000 B=4 then SLT A=-1 B=1 back-to-back -> result_o=0xF8000000, then 1; valid_o high two consecutive cycles.
- MUL 0x00010000*0x00010000, then MULHU same operands -> MUL: stall_req_o high 32 cycles, then result 0x00000000; MULHU: result 0x00000001; valid_o pulses once each, 33 cycles after each issue.
- DIVU 100/7, then REMU 100/7, then DIVU 5/0 -> results 14, 2, 0xFFFFFFFF; write_addr_o matches the latched destination.
- DIVU issued, flush_i at count=10 -> stall_req_o=0 same cycle, no valid_o, next ADD retires 1 cycle after issue.
- rst asserted mid-MUL at count=20 -> after that edge all outputs 0 and state IDLE; with EX_MULDIV_EN undefined, MUL gives result 0, illegal_o=1, stall_req_o never 1.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage.
// Single-cycle ALU ops (ADD..SLTU) retire one edge after issue. Ops 14/15 are
// illegal and retire as a zero result with illegal_o set.
// Optional macro EX_MULDIV_EN: adds an iterative 32-cycle shift-add multiplier
// and restoring divider (MUL, MULHU, DIVU, REMU). While busy it holds
// stall_req_o high, and it drops stall_req_o in the final cycle.
// Without the macro, ops 10-13 are illegal single-cycle ops and stall_req_o
// is tied to 0.
module ex_stage #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               issue_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    reg1_data_i,
  input  logic [XLEN-1:0]    reg2_data_i,
  input  logic [XLEN-1:0]    imm_data_i,
  input  logic               ctrl_ex_AluSrc_i,
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic [REG_AW-1:0]  write_addr_i,
  input  logic               ctrl_wb_RegWrite_i,
  input  logic               ctrl_wb_Mem2Reg_i,
  input  logic               ctrl_mem_branch_i,
  input  logic               ctrl_mem_read_i,
  input  logic               ctrl_mem_write_i,
  output logic               valid_o,
  output logic [XLEN-1:0]    result_o,
  output logic [XLEN-1:0]    store_data_o,
  output logic [XLEN-1:0]    branch_target_o,
  output logic               zero_o,
  output logic [REG_AW-1:0]  write_addr_o,
  output logic               ctrl_wb_RegWrite_o,
  output logic               ctrl_wb_Mem2Reg_o,
  output logic               ctrl_mem_branch_o,
  output logic               ctrl_mem_read_o,
  output logic               ctrl_mem_write_o,
  output logic               stall_req_o,
  output logic               illegal_o
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [ALUOP_W-1:0] OP_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] OP_AND   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] OP_XOR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] OP_SLL   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] OP_SRL   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] OP_SRA   = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] OP_SLT   = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] OP_SLTU  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] OP_MUL   = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] OP_MULHU = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] OP_DIVU  = ALUOP_W'(12);
  localparam logic [ALUOP_W-1:0] OP_REMU  = ALUOP_W'(13);

  logic [XLEN-1:0] opa, opb, alu_res;
  logic [SHW-1:0]  shamt;
  logic            op_ill;
  logic [4:0]      ctrl_in;

  assign opa     = reg1_data_i;
  assign opb     = ctrl_ex_AluSrc_i ? imm_data_i : reg2_data_i;
  assign shamt   = opb[SHW-1:0];
  assign ctrl_in = {ctrl_wb_RegWrite_i, ctrl_wb_Mem2Reg_i, ctrl_mem_branch_i,
                    ctrl_mem_read_i, ctrl_mem_write_i};

`ifdef EX_MULDIV_EN
  assign op_ill = (alu_op_i > OP_REMU);
`else
  assign op_ill = (alu_op_i > OP_SLTU);
`endif

  // Single-cycle ALU datapath; anything not listed yields zero
  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SLL:  alu_res = opa << shamt;
      OP_SRL:  alu_res = opa >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, opa < opb};
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL_BUSY = 2'd1, DIV_BUSY = 2'd2} state_t;

  state_t            state_q;
  logic [SHW-1:0]    cnt_q;
  // acc holds {hi, lo}: product for MUL, {remainder, quotient} for DIV
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q;     // multiplicand or divisor
  logic              hi_q;       // result taken from upper half (MULHU/REMU)
  logic [XLEN-1:0]   sd_q, bt_q;
  logic [REG_AW-1:0] wa_q;
  logic [4:0]        ctrl_q;
  logic [XLEN:0]     sum, shifted;
  logic [XLEN-1:0]   md_res;
  logic              is_md, is_mul;

  assign is_md  = (alu_op_i >= OP_MUL) && (alu_op_i <= OP_REMU);
  assign is_mul = (alu_op_i == OP_MUL) || (alu_op_i == OP_MULHU);
  assign md_res = hi_q ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];

  // One multiply (shift-add) or divide (restoring) step per cycle
  always_comb begin
    acc_d   = acc_q;
    sum     = '0;
    shifted = acc_q[2*XLEN-1:XLEN-1];
    if (state_q == MUL_BUSY) begin
      sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      acc_d = {sum, acc_q[XLEN-1:1]};
    end else if (state_q == DIV_BUSY) begin
      // divisor 0 always "fits": quotient all ones, remainder = dividend
      if (shifted >= {1'b0, opnd_q})
        acc_d = {XLEN'(shifted - {1'b0, opnd_q}), acc_q[XLEN-2:0], 1'b1};
      else
        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
    end
  end

  // Stall upstream on a mul/div issue and while busy, except the final cycle
  always_comb begin
    stall_req_o = 1'b0;
    if (!rst && !flush_i) begin
      if (state_q == IDLE) stall_req_o = issue_i && is_md;
      else                 stall_req_o = (cnt_q != SHW'(XLEN-1));
    end
  end
`else
  assign stall_req_o = 1'b0;
`endif

  // Stage FSM and EX/MEM output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o         <= 1'b0;
      result_o        <= '0;
      store_data_o    <= '0;
      branch_target_o <= '0;
      zero_o          <= 1'b0;
      write_addr_o    <= '0;
      illegal_o       <= 1'b0;
      {ctrl_wb_RegWrite_o, ctrl_wb_Mem2Reg_o, ctrl_mem_branch_o,
       ctrl_mem_read_o, ctrl_mem_write_o} <= '0;
`ifdef EX_MULDIV_EN
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= 1'b0;
      sd_q    <= '0;
      bt_q    <= '0;
      wa_q    <= '0;
      ctrl_q  <= '0;
`endif
    end else if (flush_i) begin
      // data outputs keep their last retired values
      valid_o   <= 1'b0;
      zero_o    <= 1'b0;
      illegal_o <= 1'b0;
      {ctrl_wb_RegWrite_o, ctrl_wb_Mem2Reg_o, ctrl_mem_branch_o,
       ctrl_mem_read_o, ctrl_mem_write_o} <= '0;
`ifdef EX_MULDIV_EN
      state_q <= IDLE;
`endif
    end else begin
      valid_o   <= 1'b0;
      illegal_o <= 1'b0;
      {ctrl_wb_RegWrite_o, ctrl_wb_Mem2Reg_o, ctrl_mem_branch_o,
       ctrl_mem_read_o, ctrl_mem_write_o} <= '0;
`ifdef EX_MULDIV_EN
      if (state_q != IDLE) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN-1)) begin
          valid_o         <= 1'b1;
          result_o        <= md_res;
          zero_o          <= (md_res == '0);
          store_data_o    <= sd_q;
          branch_target_o <= bt_q;
          write_addr_o    <= wa_q;
          {ctrl_wb_RegWrite_o, ctrl_wb_Mem2Reg_o, ctrl_mem_branch_o,
           ctrl_mem_read_o, ctrl_mem_write_o} <= ctrl_q;
          state_q         <= IDLE;
        end
      end else
`endif
      if (issue_i) begin
`ifdef EX_MULDIV_EN
        if (is_md) begin
          state_q <= is_mul ? MUL_BUSY : DIV_BUSY;
          cnt_q   <= '0;
          acc_q   <= {{XLEN{1'b0}}, is_mul ? opb : opa};
          opnd_q  <= is_mul ? opa : opb;
          hi_q    <= (alu_op_i == OP_MULHU) || (alu_op_i == OP_REMU);
          sd_q    <= reg2_data_i;
          bt_q    <= pc_i + imm_data_i;
          wa_q    <= write_addr_i;
          ctrl_q  <= ctrl_in;
        end else
`endif
        begin
          valid_o         <= 1'b1;
          result_o        <= op_ill ? '0 : alu_res;
          zero_o          <= op_ill ? 1'b1 : (alu_res == '0);
          store_data_o    <= reg2_data_i;
          branch_target_o <= pc_i + imm_data_i;
          write_addr_o    <= write_addr_i;
          illegal_o       <= op_ill;
          {ctrl_wb_RegWrite_o, ctrl_wb_Mem2Reg_o, ctrl_mem_branch_o,
           ctrl_mem_read_o, ctrl_mem_write_o} <= ctrl_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed test-plan cases with literal
// expectations, then a randomized stream compared every cycle against a
// transaction-level model (results from plain arithmetic, busy ops as a
// countdown to a precomputed answer).
module tb_ex_stage;

`ifdef EX_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush_i, issue_i, alusrc;
  logic [31:0] pc_i, reg1, reg2, imm;
  logic [3:0]  op;
  logic [4:0]  wa_i, ctrl_i;
  logic        valid_o, zero_o, stall_req_o, illegal_o;
  logic [31:0] result_o, store_data_o, branch_target_o;
  logic [4:0]  write_addr_o;
  logic        rw_o, m2r_o, br_o, rd_o, wr_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .issue_i(issue_i), .pc_i(pc_i),
    .reg1_data_i(reg1), .reg2_data_i(reg2), .imm_data_i(imm),
    .ctrl_ex_AluSrc_i(alusrc), .alu_op_i(op), .write_addr_i(wa_i),
    .ctrl_wb_RegWrite_i(ctrl_i[4]), .ctrl_wb_Mem2Reg_i(ctrl_i[3]),
    .ctrl_mem_branch_i(ctrl_i[2]), .ctrl_mem_read_i(ctrl_i[1]),
    .ctrl_mem_write_i(ctrl_i[0]),
    .valid_o(valid_o), .result_o(result_o), .store_data_o(store_data_o),
    .branch_target_o(branch_target_o), .zero_o(zero_o),
    .write_addr_o(write_addr_o),
    .ctrl_wb_RegWrite_o(rw_o), .ctrl_wb_Mem2Reg_o(m2r_o),
    .ctrl_mem_branch_o(br_o), .ctrl_mem_read_o(rd_o), .ctrl_mem_write_o(wr_o),
    .stall_req_o(stall_req_o), .illegal_o(illegal_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    case (o)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << b[4:0];
      6: return a >> b[4:0];
      7: return 32'($signed(a) >>> b[4:0]);
      8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: return (a < b) ? 32'd1 : 32'd0;
      10: return p[31:0];
      11: return p[63:32];
      12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] e_res, e_sd, e_bt, p_res, p_sd, p_bt;
  logic [4:0]  e_wa, e_ctrl, p_wa, p_ctrl;
  logic        e_valid, e_zero, e_ill;
  bit          m_busy = 1'b0;
  int          m_left = 0;

  function automatic bit is_md_op(input logic [3:0] o);
    return MD && (o >= 10) && (o <= 13);
  endfunction

  // Expected registered outputs after each edge
  always @(posedge clk) begin
    logic [31:0] b, r;
    bit ill;
    b = alusrc ? imm : reg2;
    if (rst) begin
      e_valid = 0; e_res = 0; e_zero = 0; e_sd = 0; e_bt = 0;
      e_wa = 0; e_ctrl = 0; e_ill = 0; m_busy = 0;
    end else if (flush_i) begin
      e_valid = 0; e_zero = 0; e_ctrl = 0; e_ill = 0; m_busy = 0;
    end else begin
      e_valid = 0; e_ctrl = 0; e_ill = 0;
      if (m_busy) begin
        if (m_left == 0) begin
          m_busy = 0; e_valid = 1; e_res = p_res; e_zero = (p_res == 0);
          e_sd = p_sd; e_bt = p_bt; e_wa = p_wa; e_ctrl = p_ctrl;
        end else m_left--;
      end else if (issue_i) begin
        if (is_md_op(op)) begin
          m_busy = 1; m_left = 31;
          p_res = ref_alu(op, reg1, b); p_sd = reg2; p_bt = pc_i + imm;
          p_wa = wa_i; p_ctrl = ctrl_i;
        end else begin
          ill = (op >= 14) || (op >= 10 && !MD);
          r = ill ? 32'd0 : ref_alu(op, reg1, b);
          e_valid = 1; e_res = r; e_zero = (r == 0); e_sd = reg2;
          e_bt = pc_i + imm; e_wa = wa_i; e_ctrl = ctrl_i; e_ill = ill;
        end
      end
    end
  end

  // Compare every cycle, mid-period
  always @(negedge clk) begin
    logic exp_stall;
    if (chk_en) begin
      exp_stall = !rst && !flush_i &&
                  (m_busy ? (m_left != 0) : (issue_i && is_md_op(op)));
      check("valid_o", 32'(valid_o), 32'(e_valid));
      check("result_o", result_o, e_res);
      check("zero_o", 32'(zero_o), 32'(e_zero));
      check("store_data_o", store_data_o, e_sd);
      check("branch_target_o", branch_target_o, e_bt);
      check("write_addr_o", 32'(write_addr_o), 32'(e_wa));
      check("ctrl_o", 32'({rw_o, m2r_o, br_o, rd_o, wr_o}), 32'(e_ctrl));
      check("illegal_o", 32'(illegal_o), 32'(e_ill));
      check("stall_req_o", 32'(stall_req_o), 32'(exp_stall));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa);
    op = o; reg1 = a; reg2 = b; alusrc = 1'b0; imm = $urandom; pc_i = $urandom;
    wa_i = wa; ctrl_i = 5'($urandom); issue_i = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

`ifdef EX_MULDIV_EN
  task automatic run_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic [31:0] exp);
    int lat, st;
    bit got;
    drive(o, a, b, wa);
    lat = 0; st = 0; got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (stall_req_o) st++;
      step();
      issue_i = 1'b0;
      lat++;
      if (valid_o) got = 1;
    end
    check("md_latency", 32'(lat), 32'd33);
    check("md_stall_cycles", 32'(st), 32'd32);
    check("md_result", result_o, exp);
    check("md_write_addr", 32'(write_addr_o), 32'(wa));
  endtask
`endif

  initial begin
    rst = 1; flush_i = 0; issue_i = 0; alusrc = 0; pc_i = 0; reg1 = 0; reg2 = 0;
    imm = 0; op = 0; wa_i = 0; ctrl_i = 0;
    step(); step();
    chk_en = 1;
    rst = 0;
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_stall", 32'(stall_req_o), 32'd0);

    // ADD wraps to zero; branch target pc+imm
    drive(4'd0, 32'hFFFF_FFFF, 32'h1234, 5'd3);
    alusrc = 1; imm = 32'd1; pc_i = 32'h100;
    step(); issue_i = 0;
    check("add_valid", 32'(valid_o), 32'd1);
    check("add_result", result_o, 32'd0);
    check("add_zero", 32'(zero_o), 32'd1);
    check("add_btarget", branch_target_o, 32'h101);

    // SRA then SLT back to back
    drive(4'd7, 32'h8000_0000, 32'd4, 5'd5);
    step();
    check("sra_result", result_o, 32'hF800_0000);
    check("sra_valid", 32'(valid_o), 32'd1);
    drive(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd6);
    step(); issue_i = 0;
    check("slt_result", result_o, 32'd1);
    check("slt_valid", 32'(valid_o), 32'd1);
    step();

`ifdef EX_MULDIV_EN
    run_md(4'd10, 32'h0001_0000, 32'h0001_0000, 5'd7, 32'h0);
    run_md(4'd11, 32'h0001_0000, 32'h0001_0000, 5'd8, 32'h1);
    run_md(4'd12, 32'd100, 32'd7, 5'd9, 32'd14);
    run_md(4'd13, 32'd100, 32'd7, 5'd10, 32'd2);
    run_md(4'd12, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF);

    // flush a DIVU in its count==10 cycle
    drive(4'd12, 32'd1000, 32'd3, 5'd12);
    step(); issue_i = 0;
    repeat (10) step();
    flush_i = 1; #1;
    check("flush_stall_drop", 32'(stall_req_o), 32'd0);
    step(); flush_i = 0;
    check("flush_no_valid", 32'(valid_o), 32'd0);
    drive(4'd0, 32'd2, 32'd3, 5'd13);
    step(); issue_i = 0;
    check("post_flush_add_valid", 32'(valid_o), 32'd1);
    check("post_flush_add_result", result_o, 32'd5);

    // reset in the count==20 cycle of a MUL
    drive(4'd10, 32'd3, 32'd5, 5'd14);
    step(); issue_i = 0;
    repeat (20) step();
    rst = 1;
    step(); rst = 0;
    check("rst_mid_valid", 32'(valid_o), 32'd0);
    check("rst_mid_result", result_o, 32'd0);
    check("rst_mid_waddr", 32'(write_addr_o), 32'd0);
    check("rst_mid_stall", 32'(stall_req_o), 32'd0);
`else
    // no mul/div unit: MUL is an illegal single-cycle op
    drive(4'd10, 32'd3, 32'd5, 5'd7);
    #1;
    check("nomd_stall", 32'(stall_req_o), 32'd0);
    step(); issue_i = 0;
    check("nomd_valid", 32'(valid_o), 32'd1);
    check("nomd_result", result_o, 32'd0);
    check("nomd_illegal", 32'(illegal_o), 32'd1);
`endif

    // randomized stream
    for (int i = 0; i < 2000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      flush_i = ($urandom_range(0, 39) == 0);
      issue_i = ($urandom_range(0, 9) < 7);
      op      = 4'($urandom);
      reg1    = pick();
      reg2    = pick();
      imm     = pick();
      alusrc  = 1'($urandom);
      pc_i    = $urandom;
      wa_i    = 5'($urandom);
      ctrl_i  = 5'($urandom);
      step();
    end
    rst = 0; flush_i = 0; issue_i = 0;
    repeat (40) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
